// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for a shared 4:1 selector: registered one-hot grant, select and burst counter.
// Optional forced hand-off after MAX_BURST cycles is compiled in with `define MUX4_ARB_BURST_LIMIT_EN.
module mux4_rr_arbiter #(
  parameter int MAX_BURST = 8,
  parameter int CNT_W     = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [3:0]       req_i,
  output logic [3:0]       gnt_o,
  output logic [1:0]       sel_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] burst_cnt_o
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_q, state_d;
  logic [1:0]       last_q, last_d;
  logic [3:0]       gnt_d;
  logic [1:0]       sel_d;
  logic [CNT_W-1:0] cnt_d;
  logic [1:0]       winner;
  logic             force_handoff;

  if (MAX_BURST < 1 || MAX_BURST > 255 || (64'(1) << CNT_W) <= 64'(MAX_BURST)) begin : g_bad_cfg
    $error("mux4_rr_arbiter: MAX_BURST must be 1..255 and below 2**CNT_W");
  end

  // First requester found scanning ptr+1, ptr+2, ptr+3, ptr (mod 4); ptr itself ranks lowest.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    rr_pick = ptr;
    for (int i = 4; i >= 1; i--) begin
      idx = ptr + 2'(i);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

  assign winner = rr_pick(req_i, last_q);

`ifdef MUX4_ARB_BURST_LIMIT_EN
  assign force_handoff = req_i[sel_o] && (burst_cnt_o == CNT_W'(MAX_BURST - 1));
`else
  assign force_handoff = 1'b0;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    gnt_d   = gnt_o;
    sel_d   = sel_o;
    last_d  = last_q;
    cnt_d   = burst_cnt_o;
    unique case (state_q)
      IDLE: begin
        if (|req_i) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << winner;
          sel_d   = winner;
          last_d  = winner;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (req_i[sel_o] && !force_handoff) begin
          if (burst_cnt_o != '1) cnt_d = burst_cnt_o + CNT_W'(1);
        end else if (|req_i) begin
          // last_q equals the holder here, so the holder ranks lowest; it wins only if alone.
          gnt_d  = 4'b0001 << winner;
          sel_d  = winner;
          last_d = winner;
          cnt_d  = '0;
        end else begin
          state_d = IDLE;
          gnt_d   = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      gnt_o       <= '0;
      sel_o       <= '0;
      last_q      <= 2'd3;
      burst_cnt_o <= '0;
    end else begin
      state_q     <= state_d;
      gnt_o       <= gnt_d;
      sel_o       <= sel_d;
      last_q      <= last_d;
      burst_cnt_o <= cnt_d;
    end
  end

  assign busy_o = |gnt_o;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed scenarios plus randomized requests
// compared against an integer-level round-robin model.
module tb_mux4_rr_arbiter;

`ifdef MUX4_ARB_BURST_LIMIT_EN
  localparam int  MB       = 4;
  localparam bit  BURST_EN = 1'b1;
`else
  localparam int  MB       = 8;
  localparam bit  BURST_EN = 1'b0;
`endif
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    req = 4'b0000;
  logic [3:0]    gnt;
  logic [1:0]    sel;
  logic          busy;
  logic [CW-1:0] cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: holder index (-1 = nobody), priority pointer, select, burst count.
  int m_hold, m_last, m_sel, m_cnt;

  mux4_rr_arbiter #(.MAX_BURST(MB), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req),
    .gnt_o(gnt), .sel_o(sel), .busy_o(busy), .burst_cnt_o(cnt)
  );

  always #5 clk = ~clk;

  function automatic int rr_winner(input logic [3:0] r, input int from);
    for (int k = 1; k <= 4; k++) begin
      int idx;
      idx = (from + k) % 4;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_hold = -1; m_last = 3; m_sel = 0; m_cnt = 0;
  endtask

  task automatic model_edge(input logic [3:0] r);
    int w;
    bit forced;
    forced = BURST_EN && (m_hold >= 0) && r[m_hold] && (m_cnt == MB - 1);
    if (m_hold >= 0 && r[m_hold] && !forced) begin
      if (m_cnt < (1 << CW) - 1) m_cnt++;
    end else begin
      w = rr_winner(r, m_last);
      if (w >= 0) begin
        m_hold = w; m_sel = w; m_last = w; m_cnt = 0;
      end else begin
        m_hold = -1; m_cnt = 0;
      end
    end
  endtask

  function automatic logic [3:0] m_gnt();
    return (m_hold < 0) ? 4'b0000 : (4'b0001 << m_hold);
  endfunction

  // Drive req, let one rising edge sample it, advance the model, then settle 1ns past the edge.
  task automatic step(input logic [3:0] r);
    req = r;
    @(posedge clk);
    model_edge(r);
    #1;
  endtask

  task automatic test_reset();
    step(4'b0100);
    step(4'b0100);
    step(4'b0100);
    checks++;
    if (gnt !== 4'b0100) begin errors++; $display("FAIL reset_setup gnt got %b want 0100", gnt); end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b want 0000", gnt); end
    checks++;
    if (sel !== 2'b00) begin errors++; $display("FAIL reset_sel got %b want 00", sel); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++;
    if (cnt !== '0) begin errors++; $display("FAIL reset_cnt got %0d want 0", cnt); end
    req = 4'b1111;
    @(posedge clk);
    #2;
    checks++;
    if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_held_gnt got %b want 0000", gnt); end
    rst_n = 1'b1;
  endtask

  task automatic test_post_reset();
    step(4'b1111);
    checks++;
    if (gnt !== 4'b0001 || sel !== 2'b00) begin
      errors++; $display("FAIL post_reset got gnt %b sel %b want 0001 00", gnt, sel);
    end
    checks++;
    if (busy !== 1'b1 || cnt !== '0) begin
      errors++; $display("FAIL post_reset_busy got busy %b cnt %0d want 1 0", busy, cnt);
    end
  endtask

  task automatic test_rotation();
    for (int h = 0; h < 4; h++) begin
      logic [3:0] r;
      logic [3:0] exp_g;
      logic [1:0] exp_s;
      r = 4'b1111;
      r[h] = 1'b0;
      exp_s = 2'((h + 1) % 4);
      exp_g = 4'b0001 << exp_s;
      step(r);
      checks++;
      if (gnt !== exp_g || sel !== exp_s || busy !== 1'b1) begin
        errors++; $display("FAIL rotation_%0d got gnt %b sel %b want %b %b", h, gnt, sel, exp_g, exp_s);
      end
    end
  endtask

  task automatic test_wrap_idle();
    step(4'b1000);
    checks++;
    if (gnt !== 4'b1000 || sel !== 2'b11) begin
      errors++; $display("FAIL wrap_hold3 got gnt %b sel %b want 1000 11", gnt, sel);
    end
    step(4'b0000);
    checks++;
    if (gnt !== 4'b0000 || sel !== 2'b11 || busy !== 1'b0 || cnt !== '0) begin
      errors++; $display("FAIL wrap_idle got gnt %b sel %b busy %b cnt %0d want 0000 11 0 0", gnt, sel, busy, cnt);
    end
    // A pulse that rises and falls between edges must not be seen.
    #2 req = 4'b0010;
    #2 req = 4'b0000;
    step(4'b0000);
    checks++;
    if (gnt !== 4'b0000) begin errors++; $display("FAIL glitch_ignored got gnt %b want 0000", gnt); end
    step(4'b0101);
    checks++;
    if (gnt !== 4'b0001 || sel !== 2'b00) begin
      errors++; $display("FAIL wrap_to0 got gnt %b sel %b want 0001 00", gnt, sel);
    end
  endtask

  task automatic test_burst();
    int cycles;
    step(4'b0010);
    checks++;
    if (gnt !== 4'b0010 || cnt !== '0) begin
      errors++; $display("FAIL burst_start got gnt %b cnt %0d want 0010 0", gnt, cnt);
    end
`ifdef MUX4_ARB_BURST_LIMIT_EN
    for (int i = 1; i < MB; i++) begin
      step(4'b0011);
      checks++;
      if (gnt !== 4'b0010 || cnt !== CW'(i)) begin
        errors++; $display("FAIL burst_count_%0d got gnt %b cnt %0d want 0010 %0d", i, gnt, cnt, i);
      end
    end
    step(4'b0011);
    checks++;
    if (gnt !== 4'b0001 || cnt !== '0) begin
      errors++; $display("FAIL burst_handoff got gnt %b cnt %0d want 0001 0", gnt, cnt);
    end
    for (int i = 0; i < MB; i++) step(4'b0010);
    checks++;
    if (gnt !== 4'b0010 || cnt !== CW'(MB - 1)) begin
      errors++; $display("FAIL burst_alone_pre got gnt %b cnt %0d want 0010 %0d", gnt, cnt, MB - 1);
    end
    step(4'b0010);
    checks++;
    if (gnt !== 4'b0010 || cnt !== '0) begin
      errors++; $display("FAIL burst_regrant got gnt %b cnt %0d want 0010 0", gnt, cnt);
    end
`else
    cycles = 0;
    for (int i = 1; i <= 24; i++) begin
      step(4'b0011);
      if (gnt === 4'b0010 && cnt === CW'(i)) cycles++;
    end
    checks++;
    if (cycles != 24) begin
      errors++; $display("FAIL noburst_hold got %0d good cycles want 24", cycles);
    end
    step(4'b0001);
    checks++;
    if (gnt !== 4'b0001 || cnt !== '0) begin
      errors++; $display("FAIL noburst_release got gnt %b cnt %0d want 0001 0", gnt, cnt);
    end
    step(4'b0010);
    for (int i = 0; i < 300; i++) step(4'b0010);
    checks++;
    if (gnt !== 4'b0010 || cnt !== '1) begin
      errors++; $display("FAIL noburst_saturate got gnt %b cnt %0d want 0010 255", gnt, cnt);
    end
`endif
  endtask

  task automatic test_random();
    logic [3:0] r;
    r = 4'b0000;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) r = 4'($urandom_range(0, 15));
      step(r);
      checks++;
      if (gnt !== m_gnt() || sel !== 2'(m_sel) || busy !== (m_hold >= 0) || cnt !== CW'(m_cnt)) begin
        errors++;
        $display("FAIL random_%0d req %b got gnt %b sel %b busy %b cnt %0d want %b %b %b %0d",
                 i, r, gnt, sel, busy, cnt, m_gnt(), 2'(m_sel), (m_hold >= 0), m_cnt);
      end
      checks++;
      if (gnt !== 4'b0000 && (!$onehot(gnt) || gnt !== (4'b0001 << sel))) begin
        errors++; $display("FAIL invariant_%0d got gnt %b sel %b", i, gnt, sel);
      end
    end
  endtask

  initial begin
    model_reset();
    #12 rst_n = 1'b1;
    test_reset();
    test_post_reset();
    test_rotation();
    test_wrap_idle();
    test_burst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter that shares the 4:1 selector datapath between four requesters. It issues a registered one-hot grant and drives the 2-bit select that steers the selector (`sel_o` feeds the selector's `sel_i`). The current holder keeps the grant while it requests. An optional burst limit forces hand-off so that no requester starves the others.

## Interface
Parameters:
- `MAX_BURST`, default 8: maximum consecutive grant cycles per holder when the burst limit is compiled in. Legal range 1..255.
- `CNT_W`, default 8: width of the burst counter. Must satisfy 2^CNT_W > MAX_BURST.

Ports:
- `clk_i`, input, 1: clock. All state changes on the rising edge.
- `rst_n_i`, input, 1: reset. Asynchronous, active-low.
- `req_i`, input, 4: request per source. Bit n = source n, which maps to selector input a/b/c/d for n = 0/1/2/3.
- `gnt_o`, output, 4: registered one-hot grant. All-zero when idle.
- `sel_o`, output, 2: registered select to the selector. Equals the index of the granted source.
- `busy_o`, output, 1: high whenever `gnt_o` is non-zero.
- `burst_cnt_o`, output, CNT_W: number of grant cycles the current holder has completed so far. 0 in the first grant cycle.

## Operation
- **State machine:** two states, IDLE and GRANT.
- **Priority pointer `last`:** holds the index of the most recent holder. Search order is `last`+1, `last`+2, `last`+3, `last`, all mod 4, so the previous holder always ranks lowest.
- **IDLE:**
  - If `req_i` is non-zero, pick the winner by search order, load `gnt_o`, `sel_o` and `last` with the winner, clear `burst_cnt_o`, and go to GRANT.
  - Otherwise stay in IDLE.
- **GRANT, holder h still requesting (`req_i[h]`=1), no forced hand-off:** hold the grant and increment `burst_cnt_o`.
- **GRANT, holder h drops its request (`req_i[h]`=0):**
  - Arbitrate among the other sources in the same cycle. There is no idle bubble.
  - If any other source requests, grant the winner and clear the counter.
  - If none requests, go to IDLE: `gnt_o`=0, `busy_o`=0, `burst_cnt_o`=0. `sel_o` and `last` hold their values.
- **Forced hand-off:** compiled only with the macro; see Configuration.
- **Request changes:** `req_i` may change on any cycle. Only the value sampled at the rising edge counts. A request pulse shorter than one cycle between edges is ignored.
- **Wrap-around:** the pointer search wraps from 3 to 0.
- **Simultaneous events:** when several sources raise requests together, the search order alone decides the winner.
- **Reset (asserted at any time, including mid-grant):** immediately forces IDLE, `gnt_o`=0, `sel_o`=0, `busy_o`=0, `burst_cnt_o`=0, `last`=3. With `last`=3, source 0 has top priority after reset.

## Timing
- **Grant latency:** a request sampled at edge N produces `gnt_o`/`sel_o` valid after edge N. The grant is visible in cycle N+1.
- **Hand-off latency:**
  - Holder drops its request, sampled at edge N: the new grant is visible after edge N.
  - The old holder and new holder are never granted in the same cycle.
  - `sel_o` changes on the same edge as `gnt_o`.
- **Selector path:** the selector is combinational, so selected data is valid in the same cycle the grant is visible.
- **Invariants:**
  - `gnt_o` is one-hot or zero at all times.
  - When `gnt_o` is non-zero, `sel_o` is the index of the set bit.
- **Reset exit:** deassertion of `rst_n_i` is sampled synchronously. The first arbitration happens on the first rising edge after release.

## Configuration
- **Macro `MUX4_ARB_BURST_LIMIT_EN`, defined:**
  - When holder h is still requesting and `burst_cnt_o` = `MAX_BURST`-1 at an edge, the arbiter re-arbitrates on that edge with h ranked lowest.
  - If another source requests, it takes the grant.
  - If not, h is re-granted with the counter cleared to 0.
  - The maximum continuous ownership under contention is therefore `MAX_BURST` cycles.
- **Macro undefined:**
  - There is no forced hand-off; the holder keeps the grant for as long as `req_i[h]`=1.
  - `burst_cnt_o` still counts but saturates at 2^CNT_W-1.
  - `MAX_BURST` is unused.

## Test plan
- **Reset:** assert `rst_n_i`=0 mid-grant held by source 2. Expect `gnt_o`=0000, `sel_o`=00, `busy_o`=0 and `burst_cnt_o`=0 immediately, without waiting for a clock edge.
- **Post-reset priority:** after reset, set `req_i`=1111 for one edge. Expect `gnt_o`=0001 and `sel_o`=00 in the next cycle.
- **Round-robin rotation:** hold `req_i`=1111 and drop each holder's request for one cycle after it is granted. Expect grants in order 0→1→2→3→0, `sel_o`=00,01,10,11,00, with no idle cycle between grants.
- **Wrap and idle:** source 3 holds the grant; `req_i` goes to 0000. Expect IDLE, `gnt_o`=0000 and `sel_o` held at 11. Then `req_i`=0101: expect `gnt_o`=0001, since the search order from `last`=3 is 0 first.
- **Burst limit (macro defined, `MAX_BURST`=4):**
  - Source 1 holds the grant with `req_i`=0011 held constant: expect `burst_cnt_o` 0,1,2,3, then `gnt_o`=0001 on the next cycle.
  - With `req_i`=0010 alone: expect source 1 re-granted and `burst_cnt_o` back at 0.
- **No burst limit (macro undefined):** same stimulus as the burst-limit test. Expect source 1 to keep `gnt_o`=0010 for 20+ cycles until `req_i[1]` drops.
